// File: rtl/system.sv
// system: UART-driven GCD calculator.
//   Two 8-bit operands arrive over UART 8N1 on rxd. Their GCD is computed by
//   repeated subtraction, shown on led and sent back over txd. The operands
//   are shown in hex on four active-low 7-segment digits.
// Ports:
//   sysclk        system clock, rising edge
//   reset         asynchronous active-low reset
//   rxd / txd     UART receive / transmit lines, both idle high
//   led[7:0]      last GCD result
//   switch[7:0]   reserved, ignored
//   digi_out1..4  segments (bit0=a .. bit6=g) for A[7:4], A[3:0], B[7:4], B[3:0]
module system #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] led,
  input  logic [7:0] switch,
  output logic [6:0] digi_out1,
  output logic [6:0] digi_out2,
  output logic [6:0] digi_out3,
  output logic [6:0] digi_out4
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
  localparam logic       GCD_IDLE = 1'b0, GCD_RUN = 1'b1;

  logic unused_switch;
  assign unused_switch = ^switch;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // rxd synchroniser; the third stage is only used for falling-edge detection
  logic rxd_m, rxd_s, rxd_d;
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  // UART receiver
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_valid;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rxd_d && !rxd_s) begin
          rx_state <= RX_START;
          rx_cnt   <= '0;
        end
        RX_START: if (rx_cnt == HALF_END) begin
          // still low at mid start bit: real frame; otherwise a glitch
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rxd_s ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + CW'(1);
        RX_DATA: if (rx_cnt == BIT_END) begin
          rx_cnt   <= '0;
          rx_shift <= {rxd_s, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end else rx_cnt <= rx_cnt + CW'(1);
        default: if (rx_cnt == BIT_END) begin
          rx_cnt   <= '0;
          rx_state <= RX_IDLE;
          if (rxd_s) begin
            rx_valid <= 1'b1;
            rx_byte  <= rx_shift;
          end
        end else rx_cnt <= rx_cnt + CW'(1);
      endcase
    end
  end

  // Operand capture and display. A completed pair is copied into pend_a/pend_b
  // so a following operand A can arrive before the held pair is consumed.
  logic       byte_cnt, pending, gcd_go;
  logic [7:0] op_a, pend_a, pend_b;
  logic       gcd_state, tx_start;
  logic [1:0] tx_state;

  assign gcd_go = pending && (gcd_state == GCD_IDLE) && (tx_state == TX_IDLE) && !tx_start;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      byte_cnt  <= 1'b0;
      pending   <= 1'b0;
      op_a      <= '0;
      pend_a    <= '0;
      pend_b    <= '0;
      digi_out1 <= '1;
      digi_out2 <= '1;
      digi_out3 <= '1;
      digi_out4 <= '1;
    end else begin
      if (gcd_go) pending <= 1'b0;
      if (rx_valid) begin
        if (!byte_cnt) begin
          op_a      <= rx_byte;
          byte_cnt  <= 1'b1;
          digi_out1 <= hex7(rx_byte[7:4]);
          digi_out2 <= hex7(rx_byte[3:0]);
          digi_out3 <= '1;
          digi_out4 <= '1;
        end else begin
          pend_a    <= op_a;
          pend_b    <= rx_byte;
          byte_cnt  <= 1'b0;
          pending   <= 1'b1;
          digi_out3 <= hex7(rx_byte[7:4]);
          digi_out4 <= hex7(rx_byte[3:0]);
        end
      end
    end
  end

  // Subtractive GCD, one step per clock
  logic [7:0] gx, gy;
  logic       gcd_done;
  assign gcd_done = (gx == 8'd0) || (gy == 8'd0) || (gx == gy);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      gcd_state <= GCD_IDLE;
      gx        <= '0;
      gy        <= '0;
      led       <= '0;
      tx_start  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (gcd_state == GCD_IDLE) begin
        if (gcd_go) begin
          gx        <= pend_a;
          gy        <= pend_b;
          gcd_state <= GCD_RUN;
        end
      end else if (gcd_done) begin
        led       <= (gx == 8'd0) ? gy : gx;
        tx_start  <= 1'b1;
        gcd_state <= GCD_IDLE;
      end else if (gx > gy) begin
        gx <= gx - gy;
      end else begin
        gy <= gy - gx;
      end
    end
  end

  // UART transmitter; sends led, which is already valid when tx_start is seen
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (tx_start) begin
            tx_state <= TX_START;
            tx_cnt   <= '0;
            tx_shift <= led;
            txd      <= 1'b0;
          end
        end
        TX_START: if (tx_cnt == BIT_END) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          txd      <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_state <= TX_DATA;
        end else tx_cnt <= tx_cnt + CW'(1);
        TX_DATA: if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            txd      <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
          end
        end else tx_cnt <= tx_cnt + CW'(1);
        default: if (tx_cnt == BIT_END) begin
          tx_cnt   <= '0;
          tx_state <= TX_IDLE;
        end else tx_cnt <= tx_cnt + CW'(1);
      endcase
    end
  end
endmodule

// File: tb/tb_system.sv
// tb_system: self-checking bench for system. Drives UART frames on rxd,
// decodes frames on txd, and compares against a Euclid-based GCD model.
module tb_system;
  localparam int CPB = 220;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       rxd    = 1'b1;
  logic       txd;
  logic [7:0] led;
  logic [7:0] switch = '0;
  logic [6:0] digi_out1, digi_out2, digi_out3, digi_out4;

  system #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk(sysclk), .reset(reset), .rxd(rxd), .txd(txd), .led(led), .switch(switch),
    .digi_out1(digi_out1), .digi_out2(digi_out2), .digi_out3(digi_out3), .digi_out4(digi_out4)
  );

  always #5 sysclk = ~sysclk;

  int unsigned cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]  tx_q[$];
  int unsigned fall_q[$];
  int unsigned last_stop_mid = 0;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_gcd(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a[7:0];
  endfunction

  // txd frame decoder
  initial begin
    logic [7:0]  b;
    int unsigned f;
    forever begin
      @(negedge sysclk);
      if (reset && txd === 1'b0) begin
        f = cyc;
        repeat (CPB / 2) @(negedge sysclk);
        check("tx_start_bit", txd, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge sysclk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge sysclk);
        check("tx_stop_bit", txd, 1);
        tx_q.push_back(b);
        fall_q.push_back(f);
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic stop);
    @(negedge sysclk);
    rxd = 1'b0;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge sysclk);
    end
    rxd = stop;
    last_stop_mid = cyc + CPB / 2;
    repeat (CPB) @(negedge sysclk);
    rxd = 1'b1;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic check_a(input string tag, input logic [7:0] a);
    check({tag, "_d1"}, digi_out1, font[a[7:4]]);
    check({tag, "_d2"}, digi_out2, font[a[3:0]]);
    check({tag, "_d3_blank"}, digi_out3, 7'h7F);
    check({tag, "_d4_blank"}, digi_out4, 7'h7F);
  endtask

  task automatic run_pair(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [7:0]  r;
    int unsigned lat;
    int          n;
    send_byte(a, 1'b1);
    check_a(tag, a);
    send_byte(b, 1'b1);
    check({tag, "_d3"}, digi_out3, font[b[7:4]]);
    check({tag, "_d4"}, digi_out4, font[b[3:0]]);
    n = 0;
    while (tx_q.size() == 0 && n < 12 * CPB + 400) begin
      @(negedge sysclk);
      n++;
    end
    check({tag, "_tx_seen"}, tx_q.size(), 1);
    if (tx_q.size() != 0) begin
      r   = tx_q.pop_front();
      lat = fall_q.pop_front() - last_stop_mid;
      check({tag, "_tx"}, r, ref_gcd(a, b));
      check({tag, "_led"}, led, ref_gcd(a, b));
      check({tag, "_lat_le_300"}, lat <= 300, 1);
    end
    repeat (CPB) @(negedge sysclk);
  endtask

  initial begin
    int n;
    switch = 8'($urandom);
    repeat (10) @(negedge sysclk);
    check("rst_txd", txd, 1);
    check("rst_led", led, 8'h00);
    check("rst_d1", digi_out1, 7'h7F);
    check("rst_d2", digi_out2, 7'h7F);
    check("rst_d3", digi_out3, 7'h7F);
    check("rst_d4", digi_out4, 7'h7F);
    reset = 1'b1;
    repeat (10) @(negedge sysclk);

    run_pair("p96b9", 8'h96, 8'hB9);
    for (int i = 0; i < 2; i++) begin
      switch = 8'($urandom);
      run_pair("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    run_pair("p0007", 8'h00, 8'h07);
    run_pair("p0000", 8'h00, 8'h00);
    run_pair("pff01", 8'hFF, 8'h01);

    // bad stop bit: dropped, display keeps FF/01
    send_byte(8'h55, 1'b0);
    check("bad_d1", digi_out1, font[15]);
    check("bad_d3", digi_out3, font[0]);
    run_pair("p0c12", 8'h0C, 8'h12);

    // lone operand A: no transmission
    send_byte(8'h1E, 1'b1);
    check_a("lone", 8'h1E);
    repeat (2 * CPB + 400) @(negedge sysclk);
    check("lone_no_tx", tx_q.size(), 0);
    check("lone_led", led, 8'h06);

    // 100-cycle glitch must not be taken as a byte
    rxd = 1'b0;
    repeat (100) @(negedge sysclk);
    rxd = 1'b1;
    repeat (10 * CPB) @(negedge sysclk);
    check_a("glitch", 8'h1E);

    // pending A still held: this byte becomes B
    send_byte(8'h2A, 1'b1);
    check("b2a_d3", digi_out3, font[2]);
    check("b2a_d4", digi_out4, font[10]);
    n = 0;
    while (txd !== 1'b0 && n < 1000) begin
      @(negedge sysclk);
      n++;
    end
    check("b2a_tx_started", txd, 0);
    check("b2a_led", led, ref_gcd(8'h1E, 8'h2A));

    // reset mid-frame
    repeat (3 * CPB) @(negedge sysclk);
    reset = 1'b0;
    #1;
    check("midrst_txd", txd, 1);
    check("midrst_led", led, 8'h00);
    check("midrst_d1", digi_out1, 7'h7F);
    @(negedge sysclk);
    reset = 1'b1;
    repeat (12 * CPB) @(negedge sysclk);
    tx_q.delete();
    fall_q.delete();

    run_pair("p080c", 8'h08, 8'h0C);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
